// File: rtl/sar_adc_ctrl_if.sv
// Bundle between the SAR controller and its analog front end / test controller.
// Handshake: start is a request sampled on a rising edge; busy covers accepted work; done is a one-cycle valid strobe for result.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp;
  logic             sample;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, cmp,
    input  sample, dac_code, busy, done, result
  );

  modport slave (
    input  start, cmp,
    output sample, dac_code, busy, done, result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples the gain-stage output, binary-searches the DAC
// code against the comparator and returns the resolved code with a busy/done handshake.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  sar_adc_ctrl_if.slave       bus,
  output logic [1:0]          dbg_state_o
);
  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int KW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [KW-1:0]    K_MSB    = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] result_q, result_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= K_MSB;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dac_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dac_q    <= dac_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dac_d    = dac_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SAMPLE;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          dac_d    = '0;
          cnt_d    = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = CONVERT;
          sample_d = 1'b0;
          dac_d    = MSB_CODE;
          k_d      = K_MSB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        // Resolve the bit under trial, then either place the next trial bit or finish.
        if (!bus.cmp) dac_d[k_q] = 1'b0;
        if (k_q != '0) begin
          dac_d[k_q - 1'b1] = 1'b1;
          k_d               = k_q - 1'b1;
        end else begin
          result_d = dac_d;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d  = SAMPLE;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          dac_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sample   = sample_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dac_code = dac_q;
  assign bus.result   = result_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: an 8-bit/2-sample and a 4-bit/1-sample instance, each with a
// binary-search reference model feeding a per-cycle timeline queue and a result queue.
module tb_sar_adc_ctrl;
  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg8, dbg4;
  logic [7:0]  vin8;
  logic [3:0]  vin4;
  int unsigned cyc_cnt;
  int          n_checks;
  int          n_fail;
  logic        end_chk;

  typedef struct {
    int unsigned cyc;
    logic        smp;
    logic        bsy;
    logic        dn;
    logic [7:0]  dac;
  } exp_t;

  exp_t       tl8_q[$];
  exp_t       tl4_q[$];
  logic [7:0] exp8_q[$];
  logic [3:0] exp4_q[$];

  sar_adc_ctrl_if #(.WIDTH(8)) b8 ();
  sar_adc_ctrl_if #(.WIDTH(4)) b4 ();

  assign b8.cmp = (vin8 >= b8.dac_code);
  assign b4.cmp = (vin4 >= b4.dac_code);

  sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8), .dbg_state_o(dbg8)
  );

  sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .dbg_state_o(dbg4)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: cycle n after acceptance edge is observed when cyc_cnt == c0 + n - 1.
  function automatic void push_conv(input bit w4, input int unsigned c0, input int vin);
    int   s;
    int   w;
    int   code;
    int   trial;
    exp_t e;
    s    = w4 ? 1 : 2;
    w    = w4 ? 4 : 8;
    code = 0;
    for (int n = 1; n <= s; n++) begin
      e = '{cyc: c0 + n - 1, smp: 1'b1, bsy: 1'b1, dn: 1'b0, dac: 8'h00};
      if (w4) tl4_q.push_back(e); else tl8_q.push_back(e);
    end
    for (int b = w - 1; b >= 0; b--) begin
      trial = code | (1 << b);
      e = '{cyc: c0 + s + (w - 1 - b), smp: 1'b0, bsy: 1'b1, dn: 1'b0, dac: 8'(trial)};
      if (w4) tl4_q.push_back(e); else tl8_q.push_back(e);
      if (vin >= trial) code = trial;
    end
    e = '{cyc: c0 + s + w, smp: 1'b0, bsy: 1'b0, dn: 1'b1, dac: 8'(code)};
    if (w4) begin
      tl4_q.push_back(e);
      exp4_q.push_back(4'(code));
    end else begin
      tl8_q.push_back(e);
      exp8_q.push_back(8'(code));
    end
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc_cnt);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_sample8", 32'(b8.sample), 0);
      chk("rst_busy8", 32'(b8.busy), 0);
      chk("rst_done8", 32'(b8.done), 0);
      chk("rst_dac8", 32'(b8.dac_code), 0);
      chk("rst_result8", 32'(b8.result), 0);
      chk("rst_done4", 32'(b4.done), 0);
      chk("rst_result4", 32'(b4.result), 0);
      chk("rst_dac4", 32'(b4.dac_code), 0);
      tl8_q.delete();
      tl4_q.delete();
      exp8_q.delete();
      exp4_q.delete();
    end else begin
      if (tl8_q.size() != 0 && tl8_q[0].cyc == cyc_cnt) begin
        e = tl8_q.pop_front();
        chk("sample8", 32'(b8.sample), 32'(e.smp));
        chk("busy8", 32'(b8.busy), 32'(e.bsy));
        chk("done8", 32'(b8.done), 32'(e.dn));
        chk("dac8", 32'(b8.dac_code), 32'(e.dac));
      end
      if (b8.done) begin
        if (exp8_q.size() == 0) chk("unexpected_done8", 1, 0);
        else chk("result8", 32'(b8.result), 32'(exp8_q.pop_front()));
      end
      if (tl4_q.size() != 0 && tl4_q[0].cyc == cyc_cnt) begin
        e = tl4_q.pop_front();
        chk("sample4", 32'(b4.sample), 32'(e.smp));
        chk("busy4", 32'(b4.busy), 32'(e.bsy));
        chk("done4", 32'(b4.done), 32'(e.dn));
        chk("dac4", 32'(b4.dac_code), 32'(e.dac));
      end
      if (b4.done) begin
        if (exp4_q.size() == 0) chk("unexpected_done4", 1, 0);
        else chk("result4", 32'(b4.result), 32'(exp4_q.pop_front()));
      end
    end
    if (end_chk) begin
      chk("pending_timeline8", tl8_q.size(), 0);
      chk("pending_result8", exp8_q.size(), 0);
      chk("pending_timeline4", tl4_q.size(), 0);
      chk("pending_result4", exp4_q.size(), 0);
    end
  end

  // Driver tasks (entered and left on a falling edge)
  task automatic conv(input bit w4, input int v, input int gap);
    int s;
    int w;
    s = w4 ? 1 : 2;
    w = w4 ? 4 : 8;
    if (w4) begin
      vin4     = v[3:0];
      b4.start = 1'b1;
    end else begin
      vin8     = v[7:0];
      b8.start = 1'b1;
    end
    push_conv(w4, cyc_cnt + 1, v);
    @(negedge clk);
    b4.start = 1'b0;
    b8.start = 1'b0;
    repeat (s + w + 1 + gap) @(negedge clk);
  endtask

  task automatic to_cycle(input int unsigned c0, input int n);
    while (cyc_cnt < c0 + n - 1) @(negedge clk);
  endtask

  initial begin
    int unsigned c0;
    n_checks = 0;
    n_fail   = 0;
    end_chk  = 1'b0;
    rst_n    = 1'b1;
    b8.start = 1'b0;
    b4.start = 1'b0;
    vin8     = 8'h00;
    vin4     = 4'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed 8-bit conversions
    conv(1'b0, 8'hA5, 0);
    conv(1'b0, 8'h00, 1);
    conv(1'b0, 8'hFF, 2);

    // start pulses in cycles 3 and 7 must be ignored
    vin8     = 8'h3C;
    b8.start = 1'b1;
    c0       = cyc_cnt + 1;
    push_conv(1'b0, c0, 8'h3C);
    @(negedge clk);
    b8.start = 1'b0;
    to_cycle(c0, 3);
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    to_cycle(c0, 7);
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    to_cycle(c0, 13);

    // start held high: back-to-back conversions
    vin8     = 8'h12;
    b8.start = 1'b1;
    c0       = cyc_cnt + 1;
    push_conv(1'b0, c0, 8'h12);
    push_conv(1'b0, c0 + 11, 8'h34);
    to_cycle(c0, 11);
    vin8 = 8'h34;
    to_cycle(c0, 22);
    b8.start = 1'b0;
    to_cycle(c0, 24);

    // Half-cycle reset during cycle 6 of a conversion
    vin8     = 8'h77;
    b8.start = 1'b1;
    c0       = cyc_cnt + 1;
    push_conv(1'b0, c0, 8'h77);
    @(negedge clk);
    b8.start = 1'b0;
    to_cycle(c0, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    repeat (14) @(negedge clk);
    conv(1'b0, 8'h55, 1);

    // Randomized 8-bit conversions
    for (int i = 0; i < 12; i++) begin
      conv(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    // Narrow instance
    conv(1'b1, 4'h9, 0);
    conv(1'b1, 4'h0, 1);
    conv(1'b1, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      conv(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    repeat (4) @(negedge clk);
    #1 end_chk = 1'b1;
    @(negedge clk);
    #1 end_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Digital successive-approximation controller that reads back the analog output of the single op-amp gain stage.
- It drives the sample switch and the capacitive DAC code, and consumes the comparator decision (stage output vs DAC).
- It returns a WIDTH-bit conversion result with a busy/done handshake to the digital test controller.
- It is the readout end of the op-amp DC/AC gain characterisation path.

Parameters:
- WIDTH, 8, number of result bits and DAC code bits (min 2).
- SAMPLE_CYCLES, 2, number of clock cycles the sample switch is held closed (min 1).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled on the rising edge.
- cmp  input  1  comparator decision: 1 = stage output >= DAC level. Must be settled and synchronous to clk one cycle after dac_code changes.
- sample  output  1  sample/track switch enable.
- dac_code  output  WIDTH  trial code to the capacitive DAC.
- busy  output  1  high from accepted start until done is issued.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  last completed conversion; holds until the next done.

Behaviour:
- Reset: asynchronous on rst_n low. Outputs take these values immediately:
  - state = IDLE
  - sample = 0, dac_code = 0, busy = 0, done = 0, result = 0
  - bit index = WIDTH-1, sample counter = 0
- All outputs are registered; there are no combinational paths from start or cmp to any output.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - start = 1 at an edge -> SAMPLE.
  - At that edge: sample <= 1, busy <= 1, dac_code <= 0, counter <= 0.
- SAMPLE:
  - counter increments each cycle.
  - When counter == SAMPLE_CYCLES-1 -> CONVERT.
  - At that edge: sample <= 0, dac_code <= MSB only (1 << (WIDTH-1)), bit index k <= WIDTH-1.
- CONVERT, one cycle per bit, at each edge:
  - If cmp == 0, clear bit k of dac_code; if cmp == 1, keep it.
  - If k > 0: set bit k-1 and decrement k.
  - If k == 0: result <= resolved code (bit 0 included), dac_code holds the resolved code, -> DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle.
  - If start = 1 at the edge leaving DONE: go straight to SAMPLE with the same entry actions as from IDLE (back-to-back conversion).
  - Otherwise -> IDLE, done <= 0.
- Latency: with start accepted at edge 0, sample is high for cycles 1..SAMPLE_CYCLES and CONVERT runs WIDTH cycles. done is high in cycle SAMPLE_CYCLES+WIDTH+1 (11 at defaults). Throughput is one conversion per SAMPLE_CYCLES+WIDTH+1 cycles.
- start while in SAMPLE or CONVERT is ignored, with no queuing.
- Boundaries:
  - Comparator always 1 -> result = all ones. Always 0 -> result = 0.
  - The MSB trial uses dac_code bit WIDTH-1 only; there is no overflow or wrap and the code never exceeds 2^WIDTH-1.
- Reset mid-conversion: the conversion is aborted and result returns to 0. No done pulse is issued for the aborted conversion.
- sample and busy never glitch between states.
- dac_code is stable for an entire CONVERT cycle.

Test Plan:
- Defaults, behavioural comparator cmp = (vin_code >= dac_code), vin_code = 0xA5, start pulse at edge 0 -> sample high cycles 1-2; dac_code sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; done in cycle 11; result = 0xA5; busy high cycles 1-10.
- vin_code = 0x00 -> result 0x00. vin_code = 0xFF -> result 0xFF. Both with done in cycle 11.
- start pulsed again in cycles 3 and 7 during a vin_code = 0x3C conversion -> ignored; a single done; result 0x3C.
- start held high continuously with vin_code 0x12 then 0x34 -> done in cycles 11 and 22; results 0x12 then 0x34; no IDLE cycle between the two conversions.
- rst_n low for half a cycle during cycle 6 of a conversion -> all outputs are 0 immediately; no done; a following start with vin_code 0x55 yields 0x55 with the normal latency.
- WIDTH = 4, SAMPLE_CYCLES = 1, vin_code = 0x9 -> dac_code 0x8, 0xC, 0xA, 0x9; done in cycle 6; result 0x9.
